// File: rtl/sccb_responder.sv
// SCCB/I2C write-target with a 256x8 register file, used in place of a camera register interface.
// Define SCCB_READ_EN to compile in register read-back; otherwise read-address bytes are NACKed.
module sccb_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    // state   | meaning
    // IDLE    | bus free or reset, waiting for START
    // DEV     | shifting in device address + R/W
    // ACK_DEV | driving ACK for the device address
    // SUB     | shifting in register sub-address
    // ACK_SUB | driving ACK for the sub-address
    // WR      | shifting in a data byte
    // ACK_WR  | driving ACK, byte committed on entry
    // IGNORE  | not addressed, SDA released until START/STOP
    // RD      | driving mem[ptr] out MSB first
    // RD_ACK  | SDA released, sampling master ACK/NACK
    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WR, ACK_WR, IGNORE
`ifdef SCCB_READ_EN
        , RD, RD_ACK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sh, sda_sh;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d, ptr_inc;
    logic        sda_oe_d, busy_d, wr_strobe_d, mem_we, addr_ok;
    logic [7:0]  wr_addr_d, wr_data_d;
    logic [7:0]  mem [256];
`ifdef SCCB_READ_EN
    logic [6:0]  rd_shift_q, rd_shift_d;
    logic        m_nack_q, m_nack_d;
`endif

    // [0],[1] synchronize, [2] is the history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], scl};
            sda_sh <= {sda_sh[1:0], sda_in};
        end
    end

    wire scl_rise  = scl_sh[1] & ~scl_sh[2];
    wire scl_fall  = ~scl_sh[1] & scl_sh[2];
    wire start_det = scl_sh[1] & scl_sh[2] & ~sda_sh[1] & sda_sh[2];
    wire stop_det  = scl_sh[1] & scl_sh[2] & sda_sh[1] & ~sda_sh[2];
    wire sda_now   = sda_sh[1];

    assign ptr_inc  = ptr_q + 8'd1;
    assign dbg_data = mem[dbg_addr];
`ifdef SCCB_READ_EN
    assign addr_ok = (shift_q[7:1] == DEV_ADDR);
`else
    assign addr_ok = (shift_q == {DEV_ADDR, 1'b0});
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe;
        busy_d      = busy;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        mem_we      = 1'b0;
`ifdef SCCB_READ_EN
        rd_shift_d  = rd_shift_q;
        m_nack_d    = m_nack_q;
`endif
        if (stop_det) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = DEV;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            if (scl_rise && bit_cnt_q != 4'd8 &&
                (state_q == DEV || state_q == SUB || state_q == WR)) begin
                shift_d   = {shift_q[6:0], sda_now};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
`ifdef SCCB_READ_EN
            if (scl_rise && state_q == RD_ACK)
                m_nack_d = sda_now;
`endif
            if (scl_fall) begin
                case (state_q)
                    DEV: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (addr_ok) begin
                            sda_oe_d = 1'b1;
                            state_d  = ACK_DEV;
                        end else begin
                            state_d  = IGNORE;
                        end
                    end
                    ACK_DEV: begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = SUB;
`ifdef SCCB_READ_EN
                        if (shift_q[0]) begin
                            rd_shift_d = mem[ptr_q][6:0];
                            sda_oe_d   = ~mem[ptr_q][7];
                            bit_cnt_d  = 4'd1;
                            state_d    = RD;
                        end
`endif
                    end
                    SUB: if (bit_cnt_q == 4'd8) begin
                        ptr_d     = shift_q;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        state_d   = ACK_SUB;
                    end
                    ACK_SUB, ACK_WR: begin
                        sda_oe_d = 1'b0;
                        state_d  = WR;
                    end
                    WR: if (bit_cnt_q == 4'd8) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = shift_q;
                        ptr_d       = ptr_inc;
                        bit_cnt_d   = 4'd0;
                        sda_oe_d    = 1'b1;
                        state_d     = ACK_WR;
                    end
`ifdef SCCB_READ_EN
                    RD: if (bit_cnt_q != 4'd8) begin
                        sda_oe_d   = ~rd_shift_q[6];
                        rd_shift_d = {rd_shift_q[5:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_ACK;
                    end
                    RD_ACK: if (!m_nack_q) begin
                        ptr_d      = ptr_inc;
                        rd_shift_d = mem[ptr_inc][6:0];
                        sda_oe_d   = ~mem[ptr_inc][7];
                        bit_cnt_d  = 4'd1;
                        state_d    = RD;
                    end else begin
                        state_d = IGNORE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
`ifdef SCCB_READ_EN
            rd_shift_q <= 7'd0;
            m_nack_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe     <= sda_oe_d;
            busy       <= busy_d;
            wr_strobe  <= wr_strobe_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
`ifdef SCCB_READ_EN
            rd_shift_q <= rd_shift_d;
            m_nack_q   <= m_nack_d;
`endif
        end
    end

    // register file is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ptr_q] <= shift_q;
    end

endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB/I2C target (responder) that is the far end of the camera-configuration bus: it decodes 3-phase SCCB write transactions from the configuration master and stores them in a 256×8 register file, as the OV7670 does. It sits in simulation benches and loopback builds in place of the camera's register interface, letting the configuration master be exercised and its register image inspected without a sensor. It also acknowledges each byte so that full I2C masters can run against it.

## Interface
- DEV_ADDR, 7'h21, 7-bit target address (write byte 8'h42, read byte 8'h43).
- CLK_PER_SCL_MIN, 16, documented minimum ratio of clk to scl; not enforced in RTL.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- scl  in  1  bus clock from master, asynchronous.
- sda_in  in  1  bus data as seen on the pad, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- busy  out  1  high from START detect to STOP detect.
- wr_strobe  out  1  one-cycle pulse per committed register write.
- wr_addr  out  8  register address of the last commit.
- wr_data  out  8  data of the last commit.
- dbg_addr  in  8  register-file peek address.
- dbg_data  out  8  combinational mem[dbg_addr].

## Operation
- scl and sda_in pass through a 2-flop synchronizer, then a history flop for edge detection.
- START: sda falls while scl is high. STOP: sda rises while scl is high. Both are valid in any state.
- Data bits are sampled on the detected scl rise, MSB first.
- sda_oe changes only on the detected scl fall.
- States and transitions:
  - IDLE -> DEV on START.
  - DEV: 8 bits. If addr == DEV_ADDR, go to ACK_DEV; otherwise go to IGNORE with SDA released (NACK).
  - ACK_DEV: drive low for one bit time. Then go to SUB if R/W=0, or to RD if R/W=1 (see Configuration).
  - SUB: 8 bits loaded into the pointer. ACK_SUB drives low, then go to WR.
  - WR: 8 bits. ACK_WR drives low. On the fall that asserts the ACK:
    - mem[ptr] <= byte,
    - wr_addr <= ptr, wr_data <= byte, wr_strobe pulses,
    - ptr increments, wrapping 8'hFF -> 8'h00.
  - Further bytes repeat WR/ACK_WR (burst).
  - IGNORE: wait for START or STOP; never drive SDA.
- STOP in any state -> IDLE. A partial byte is discarded, with no commit and no pointer change.
- Repeated START in any state -> DEV. Bit count clears; the pointer is retained.
- The pointer persists between transactions, for SCCB 2-phase write followed by read.

## Timing
- Bus event to internal detect: 3 clk cycles.
- sda_oe asserts 1 cycle after the detected scl fall that follows bit 8.
- sda_oe releases 1 cycle after the next detected scl fall.
- wr_strobe is high exactly 1 cycle, coincident with sda_oe rising in ACK_WR.
- Reset values:
  - sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0;
  - pointer=0, state=IDLE.
- Register-file contents are not reset; they are unknown until written.
- Reset asserted mid-transaction releases SDA on the next clk. The bus is then ignored until a fresh START.
- The block requires clk ≥ 16× scl frequency. Below this, behaviour is undefined.

## Configuration
- SCCB_READ_EN defined (read support compiled in):
  - An address match with R/W=1 is ACKed, then RD shifts out mem[ptr] MSB first, changing sda_oe on each scl fall (sda_oe = ~bit).
  - After bit 8, SDA is released and the master's ACK is sampled.
    - Master ACK (0): ptr++ (wrapping), next byte.
    - Master NACK (1): go to IGNORE until STOP.
- SCCB_READ_EN undefined: a read-address byte (8'h43) is NACKed and the block goes to IGNORE. No read logic is synthesised.

## Test plan
- Write: START, 8'h42, 8'h12, 8'h80, STOP.
  - Expect three ACKs and a single wr_strobe with wr_addr=8'h12, wr_data=8'h80.
  - Expect dbg_addr=8'h12 -> dbg_data=8'h80, and busy low after STOP.
- Address mismatch: START, 8'h60, 8'h12, 8'h55, STOP.
  - Expect sda_oe never asserted, no wr_strobe, and mem[8'h12] unchanged.
- Burst with wrap: write at sub-address 8'hFF the bytes 8'hAA and 8'hBB.
  - Expect mem[8'hFF]=8'hAA and mem[8'h00]=8'hBB, with two wr_strobe pulses.
- Abort: STOP after 5 bits of the data byte.
  - Expect no wr_strobe and state IDLE.
  - A following full write to 8'h3A of 8'h04 must succeed.
- Read (SCCB_READ_EN): after writing 8'h5C to 8'h40, run a 2-phase write of sub-address 8'h40, STOP, then START, 8'h43, and read one byte with master NACK.
  - Expect the bits 0,1,0,1,1,1,0,0 on SDA.
  - Without the macro, expect 8'h43 to be NACKed.
- Reset mid-ACK: assert reset while sda_oe=1.
  - Expect sda_oe=0 on the next clk, all outputs at their reset values, and a new transaction to work normally.
